wash_cycle_sequencer: RTL and testbench

- Parametrised next-generation washing-machine cycle controller.
- Configurable rinse count, sensor and actuator widths, and programmable per-phase durations.
- Built-in phase timer with pause/resume that preserves remaining time.
- Fill/drain watchdogs, coded fault reporting, and a recoverable vibration fault.
- Sits between the front-panel/config logic and the actuator drivers; needs no external timer.

---
 rtl/wash_pkg.sv | 44 ++++
 rtl/wash_phase_timer.sv | 43 ++++
 rtl/wash_cycle_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_wash_cycle_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared state encoding, fault codes and state-class helpers for the
// wash cycle sequencer.
package wash_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FILL        = 4'd1,
        HEAT        = 4'd2,
        PREWASH     = 4'd3,
        WASH        = 4'd4,
        DRAIN       = 4'd5,
        RINSE_FILL  = 4'd6,
        RINSE       = 4'd7,
        RINSE_DRAIN = 4'd8,
        SPIN        = 4'd9,
        DONE        = 4'd10,
        PAUSED      = 4'd11,
        ABORT_DRAIN = 4'd12,
        FAULT       = 4'd13
    } state_t;

    localparam logic [1:0] FAULT_NONE      = 2'd0;
    localparam logic [1:0] FAULT_FILL_TO   = 2'd1;
    localparam logic [1:0] FAULT_DRAIN_TO  = 2'd2;
    localparam logic [1:0] FAULT_VIBRATION = 2'd3;

    function automatic logic is_timed(input state_t s);
        return s inside {PREWASH, WASH, RINSE, SPIN};
    endfunction

    function automatic logic is_fill(input state_t s);
        return s inside {FILL, RINSE_FILL};
    endfunction

    function automatic logic is_drain(input state_t s);
        return s inside {DRAIN, RINSE_DRAIN};
    endfunction

    function automatic logic is_pausable(input state_t s);
        return s inside {FILL, HEAT, PREWASH, WASH, DRAIN, RINSE_FILL,
                         RINSE, RINSE_DRAIN, SPIN};
    endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Phase timer: TICK_DIV-cycle prescaler feeding a saturating down-counter.
// load restarts both; freeze holds both; expired flags remaining == 0.
module wash_phase_timer #(
    parameter int TIME_W   = 16,
    parameter int TICK_DIV = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              run,
    input  logic              freeze,
    output logic [TIME_W-1:0] remaining,
    output logic              expired
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] prescale;

    // Prescaler and down-counter; count only while running and not frozen
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale  <= '0;
            remaining <= '0;
        end else if (load) begin
            prescale  <= '0;
            remaining <= load_val;
        end else if (run && !freeze) begin
            if (prescale == PRE_LAST) begin
                prescale <= '0;
                if (remaining != '0)
                    remaining <= remaining - TIME_W'(1);
            end else begin
                prescale <= prescale + PRE_W'(1);
            end
        end
    end

    assign expired = (remaining == '0);

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine cycle sequencer: fill/heat/wash/rinse/spin FSM with
// pause/resume, stop, fill/drain watchdogs and recoverable vibration fault.
// Optional macro WASH_PREWASH_EN adds a prewash_time port and PREWASH phase.
module wash_cycle_sequencer
    import wash_pkg::*;
#(
    parameter int LEVEL_W       = 10,
    parameter int TEMP_W        = 7,
    parameter int SPEED_W       = 11,
    parameter int TIME_W        = 16,
    parameter int NUM_RINSE     = 2,
    parameter int TICK_DIV      = 1000,
    parameter int FILL_TIMEOUT  = 4096,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               resume,
    input  logic               door_closed,
    input  logic [LEVEL_W-1:0] target_level,
    input  logic [TEMP_W-1:0]  target_temp,
    input  logic [SPEED_W-1:0] spin_speed,
    input  logic [TIME_W-1:0]  wash_time,
    input  logic [TIME_W-1:0]  rinse_time,
    input  logic [TIME_W-1:0]  spin_time,
`ifdef WASH_PREWASH_EN
    input  logic [TIME_W-1:0]  prewash_time,
`endif
    input  logic [LEVEL_W-1:0] level_sensor,
    input  logic [TEMP_W-1:0]  temp_sensor,
    input  logic               vibration,
    output logic               door_lock,
    output logic               water_valve,
    output logic               heater,
    output logic               drain_pump,
    output logic [SPEED_W-1:0] drum_motor,
    output logic [3:0]         state_o,
    output logic [3:0]         rinse_idx,
    output logic [TIME_W-1:0]  remaining,
    output logic               busy,
    output logic               done,
    output logic [1:0]         fault_code
);

    localparam int WD_MAX = (FILL_TIMEOUT > DRAIN_TIMEOUT) ? FILL_TIMEOUT : DRAIN_TIMEOUT;
    localparam int WD_W   = $clog2(WD_MAX + 1);
    localparam logic [WD_W-1:0] FILL_LAST  = WD_W'(FILL_TIMEOUT - 1);
    localparam logic [WD_W-1:0] DRAIN_LAST = WD_W'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0]      RINSE_LAST = 4'(NUM_RINSE - 1);

    state_t state, next_state, saved_state;
    logic [1:0]         next_fault;
    logic [WD_W-1:0]    wd;
    logic [LEVEL_W-1:0] cfg_level;
    logic [TEMP_W-1:0]  cfg_temp;
    logic [SPEED_W-1:0] cfg_speed;
    logic [TIME_W-1:0]  cfg_wash, cfg_rinse, cfg_spin;
`ifdef WASH_PREWASH_EN
    logic [TIME_W-1:0]  cfg_prewash;
`endif
    logic               tmr_load, tmr_expired;
    logic [TIME_W-1:0]  tmr_load_val;
    logic               fill_to, drain_to;
    state_t             after_fill;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Saved state, fault code, rinse pass, watchdog and configuration latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            saved_state <= IDLE;
            fault_code  <= FAULT_NONE;
            rinse_idx   <= '0;
            wd          <= '0;
            cfg_level   <= '0;
            cfg_temp    <= '0;
            cfg_speed   <= '0;
            cfg_wash    <= '0;
            cfg_rinse   <= '0;
            cfg_spin    <= '0;
`ifdef WASH_PREWASH_EN
            cfg_prewash <= '0;
`endif
        end else begin
            fault_code <= next_fault;
            if ((next_state == PAUSED || next_state == FAULT) && next_state != state)
                saved_state <= state;
            if (next_state == ABORT_DRAIN || state == DONE)
                rinse_idx <= '0;
            else if (state == RINSE_DRAIN && next_state == RINSE_FILL)
                rinse_idx <= rinse_idx + 4'd1;
            // Pausing and resuming keep the watchdog count; other changes clear it
            if (next_state != state) begin
                if (next_state != PAUSED && state != PAUSED)
                    wd <= '0;
            end else if (is_fill(state) || is_drain(state)) begin
                wd <= wd + WD_W'(1);
            end
            if (state == IDLE && start && door_closed) begin
                cfg_level   <= target_level;
                cfg_temp    <= target_temp;
                cfg_speed   <= spin_speed;
                cfg_wash    <= wash_time;
                cfg_rinse   <= rinse_time;
                cfg_spin    <= spin_time;
`ifdef WASH_PREWASH_EN
                cfg_prewash <= prewash_time;
`endif
            end
        end
    end

    assign fill_to  = is_fill(state)  && (wd == FILL_LAST);
    assign drain_to = is_drain(state) && (wd == DRAIN_LAST);

`ifdef WASH_PREWASH_EN
    assign after_fill = PREWASH;
`else
    assign after_fill = (cfg_temp == '0) ? WASH : HEAT;
`endif

    // Next-state logic: stop > vibration > pause > normal transition
    always_comb begin
        next_state = state;
        next_fault = fault_code;
        if (stop && state != IDLE && state != DONE) begin
            next_state = ABORT_DRAIN;
            next_fault = FAULT_NONE;
        end else if (vibration && (state inside {WASH, RINSE, SPIN})) begin
            next_state = FAULT;
            next_fault = FAULT_VIBRATION;
        end else if (pause && is_pausable(state)) begin
            next_state = PAUSED;
        end else begin
            case (state)
                IDLE:        if (start && door_closed) next_state = FILL;
                FILL: begin
                    if (fill_to) begin
                        next_state = FAULT;
                        next_fault = FAULT_FILL_TO;
                    end else if (level_sensor >= cfg_level) begin
                        next_state = after_fill;
                    end
                end
`ifdef WASH_PREWASH_EN
                PREWASH:     if (tmr_expired) next_state = (cfg_temp == '0) ? WASH : HEAT;
`endif
                HEAT:        if (temp_sensor >= cfg_temp) next_state = WASH;
                WASH:        if (tmr_expired) next_state = DRAIN;
                DRAIN: begin
                    if (drain_to) begin
                        next_state = FAULT;
                        next_fault = FAULT_DRAIN_TO;
                    end else if (level_sensor == '0) begin
                        next_state = RINSE_FILL;
                    end
                end
                RINSE_FILL: begin
                    if (fill_to) begin
                        next_state = FAULT;
                        next_fault = FAULT_FILL_TO;
                    end else if (level_sensor >= cfg_level) begin
                        next_state = RINSE;
                    end
                end
                RINSE:       if (tmr_expired) next_state = RINSE_DRAIN;
                RINSE_DRAIN: begin
                    if (drain_to) begin
                        next_state = FAULT;
                        next_fault = FAULT_DRAIN_TO;
                    end else if (level_sensor == '0) begin
                        next_state = (rinse_idx < RINSE_LAST) ? RINSE_FILL : SPIN;
                    end
                end
                SPIN:        if (tmr_expired) next_state = DONE;
                DONE:        next_state = IDLE;
                PAUSED:      if (resume) next_state = saved_state;
                ABORT_DRAIN: if (level_sensor == '0) next_state = IDLE;
                FAULT: begin
                    if (fault_code == FAULT_VIBRATION && resume && !vibration) begin
                        next_state = saved_state;
                        next_fault = FAULT_NONE;
                    end
                end
                default:     next_state = IDLE;
            endcase
        end
    end

    // Timer reload on fresh entry into a timed phase (not on return from PAUSED/FAULT)
    always_comb begin
        tmr_load     = is_timed(next_state) && next_state != state &&
                       state != PAUSED && state != FAULT;
        tmr_load_val = '0;
        case (next_state)
            WASH:    tmr_load_val = cfg_wash;
            RINSE:   tmr_load_val = cfg_rinse;
            SPIN:    tmr_load_val = cfg_spin;
`ifdef WASH_PREWASH_EN
            PREWASH: tmr_load_val = cfg_prewash;
`endif
            default: tmr_load_val = '0;
        endcase
    end

    wash_phase_timer #(
        .TIME_W   (TIME_W),
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (tmr_load),
        .load_val  (tmr_load_val),
        .run       (is_timed(state)),
        .freeze    (next_state != state),
        .remaining (remaining),
        .expired   (tmr_expired)
    );

    // Moore actuator decode from the registered state
    always_comb begin
        water_valve = 1'b0;
        heater      = 1'b0;
        drain_pump  = 1'b0;
        drum_motor  = '0;
        done        = 1'b0;
        case (state)
            FILL, RINSE_FILL:                water_valve = 1'b1;
            HEAT:                            heater      = (temp_sensor < cfg_temp);
            PREWASH:                         drum_motor  = cfg_speed >> 1;
            WASH, RINSE:                     drum_motor  = cfg_speed;
            DRAIN, RINSE_DRAIN, ABORT_DRAIN: drain_pump  = 1'b1;
            SPIN: begin
                drain_pump = 1'b1;
                drum_motor = cfg_speed;
            end
            DONE:                            done        = 1'b1;
            default: ;
        endcase
    end

    assign door_lock = (state != IDLE) && (state != DONE);
    assign busy      = (state != IDLE);
    assign state_o   = state;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed self-checking bench for wash_cycle_sequencer (default build).
module tb_wash_cycle_sequencer;

    localparam int S_IDLE = 0, S_FILL = 1, S_HEAT = 2, S_WASH = 4, S_DRAIN = 5,
                   S_RINSE_FILL = 6, S_RINSE = 7, S_RINSE_DRAIN = 8, S_SPIN = 9,
                   S_DONE = 10, S_PAUSED = 11, S_ABORT = 12, S_FAULT = 13;

    logic        clk = 1'b0;
    logic        reset_n, start, stop, pause, resume, door_closed, vibration;
    logic [9:0]  target_level, level_sensor;
    logic [6:0]  target_temp, temp_sensor;
    logic [10:0] spin_speed, drum_motor;
    logic [15:0] wash_time, rinse_time, spin_time, remaining;
    logic        door_lock, water_valve, heater, drain_pump, busy, done;
    logic [3:0]  state_o, rinse_idx;
    logic [1:0]  fault_code;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int n;

    wash_cycle_sequencer #(
        .LEVEL_W(10), .TEMP_W(7), .SPEED_W(11), .TIME_W(16), .NUM_RINSE(2),
        .TICK_DIV(1), .FILL_TIMEOUT(64), .DRAIN_TIMEOUT(64)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
        .resume(resume), .door_closed(door_closed), .target_level(target_level),
        .target_temp(target_temp), .spin_speed(spin_speed), .wash_time(wash_time),
        .rinse_time(rinse_time), .spin_time(spin_time), .level_sensor(level_sensor),
        .temp_sensor(temp_sensor), .vibration(vibration), .door_lock(door_lock),
        .water_valve(water_valve), .heater(heater), .drain_pump(drain_pump),
        .drum_motor(drum_motor), .state_o(state_o), .rinse_idx(rinse_idx),
        .remaining(remaining), .busy(busy), .done(done), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic dwell(input int st, output int cnt);
        cnt = 0;
        while (state_o === 4'(st) && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic goto_state(input string tag, input int st, input int budget);
        int k = 0;
        while (state_o !== 4'(st) && k < budget) begin
            tick();
            k++;
        end
        chk(tag, state_o, st);
    endtask

    initial begin
        reset_n = 0; start = 0; stop = 0; pause = 0; resume = 0; vibration = 0;
        door_closed = 1; target_level = 300; target_temp = 40; spin_speed = 1200;
        wash_time = 5; rinse_time = 3; spin_time = 4; level_sensor = 0; temp_sensor = 20;
        repeat (3) tick();
        chk("rst_state", state_o, S_IDLE);
        chk("rst_outs", {door_lock, water_valve, heater, drain_pump, busy, done}, 0);
        chk("rst_drum", drum_motor, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_fault", fault_code, 0);
        reset_n = 1;
        tick();

        // Nominal cycle
        start = 1; tick(); start = 0;
        target_level = 900;  // must be ignored: 300 is latched
        chk("t1_fill", state_o, S_FILL);
        chk("t1_fill_valve", water_valve, 1);
        chk("t1_fill_lock", door_lock, 1);
        chk("t1_busy", busy, 1);
        level_sensor = 300; tick();
        chk("t1_heat", state_o, S_HEAT);
        chk("t1_heater_on", heater, 1);
        temp_sensor = 40; #1;
        chk("t1_heater_off", heater, 0);
        tick();
        chk("t1_wash", state_o, S_WASH);
        chk("t1_wash_rem", remaining, 5);
        chk("t1_wash_drum", drum_motor, 1200);
        dwell(S_WASH, n);
        chk("t1_wash_len", n, 6);
        chk("t1_drain", state_o, S_DRAIN);
        chk("t1_drain_pump", drain_pump, 1);
        chk("t1_drain_drum", drum_motor, 0);
        level_sensor = 0; tick();
        chk("t1_rf0", state_o, S_RINSE_FILL);
        chk("t1_rf0_idx", rinse_idx, 0);
        level_sensor = 300; tick();
        chk("t1_rinse0", state_o, S_RINSE);
        chk("t1_rinse0_rem", remaining, 3);
        dwell(S_RINSE, n);
        chk("t1_rinse0_len", n, 4);
        chk("t1_rd0", state_o, S_RINSE_DRAIN);
        level_sensor = 0; tick();
        chk("t1_rf1", state_o, S_RINSE_FILL);
        chk("t1_rf1_idx", rinse_idx, 1);
        level_sensor = 300; tick();
        dwell(S_RINSE, n);
        chk("t1_rinse1_len", n, 4);
        level_sensor = 0; tick();
        chk("t1_spin", state_o, S_SPIN);
        chk("t1_spin_rem", remaining, 4);
        chk("t1_spin_act", {drain_pump, drum_motor}, {1'b1, 11'd1200});
        dwell(S_SPIN, n);
        chk("t1_spin_len", n, 5);
        chk("t1_done", state_o, S_DONE);
        chk("t1_done_pulse", done, 1);
        chk("t1_done_unlock", door_lock, 0);
        tick();
        chk("t1_idle", state_o, S_IDLE);
        chk("t1_idle_done", done, 0);
        chk("t1_idle_idx", rinse_idx, 0);
        chk("t1_done_count", done_cnt, 1);

        // Pause in WASH at remaining=3
        target_level = 300; level_sensor = 300; temp_sensor = 40;
        start = 1; tick(); start = 0;
        tick(); tick();
        chk("t2_wash", state_o, S_WASH);
        chk("t2_rem5", remaining, 5);
        tick(); tick();
        chk("t2_rem3", remaining, 3);
        pause = 1; tick();
        chk("t2_paused", state_o, S_PAUSED);
        chk("t2_p_rem", remaining, 3);
        chk("t2_p_act", {water_valve, heater, drain_pump, drum_motor}, 0);
        chk("t2_p_lock", door_lock, 1);
        repeat (19) tick();
        chk("t2_p_hold", state_o, S_PAUSED);
        chk("t2_p_hold_rem", remaining, 3);
        resume = 1; tick(); resume = 0; pause = 0;
        chk("t2_resumed", state_o, S_WASH);
        chk("t2_res_rem", remaining, 3);
        chk("t2_res_drum", drum_motor, 1200);
        tick();
        chk("t2_rem2", remaining, 2);
        dwell(S_WASH, n);
        chk("t2_tail_len", n, 3);
        chk("t2_drain", state_o, S_DRAIN);

        // Stop during the second RINSE pass with water in the drum
        level_sensor = 0;   goto_state("t3_rf0", S_RINSE_FILL, 10);
        level_sensor = 500; goto_state("t3_r0", S_RINSE, 10);
        level_sensor = 0;   goto_state("t3_rf1", S_RINSE_FILL, 20);
        chk("t3_idx1", rinse_idx, 1);
        level_sensor = 500; goto_state("t3_r1", S_RINSE, 10);
        stop = 1; tick(); stop = 0;
        chk("t3_abort", state_o, S_ABORT);
        chk("t3_abort_act", {water_valve, heater, drain_pump, drum_motor}, {3'b001, 11'd0});
        chk("t3_abort_idx", rinse_idx, 0);
        chk("t3_abort_lock", door_lock, 1);
        tick();
        chk("t3_abort_hold", state_o, S_ABORT);
        level_sensor = 0; tick();
        chk("t3_idle", state_o, S_IDLE);
        chk("t3_unlock", {door_lock, busy}, 0);

        // Fill watchdog timeout
        start = 1; tick(); start = 0;
        chk("t4_fill", state_o, S_FILL);
        dwell(S_FILL, n);
        chk("t4_fill_len", n, 64);
        chk("t4_fault", state_o, S_FAULT);
        chk("t4_code", fault_code, 1);
        chk("t4_fault_act", {water_valve, drain_pump, door_lock}, 3'b001);
        resume = 1; tick(); resume = 0;
        chk("t4_resume_ign", state_o, S_FAULT);
        chk("t4_code_hold", fault_code, 1);
        stop = 1; tick(); stop = 0;
        chk("t4_abort", state_o, S_ABORT);
        chk("t4_code_clr", fault_code, 0);
        tick();
        chk("t4_idle", state_o, S_IDLE);

        // Vibration fault in SPIN
        level_sensor = 300; temp_sensor = 40;
        start = 1; tick(); start = 0;
        goto_state("t5_wash", S_WASH, 10);
        level_sensor = 0;   goto_state("t5_rf0", S_RINSE_FILL, 20);
        level_sensor = 300; goto_state("t5_r0", S_RINSE, 10);
        level_sensor = 0;   goto_state("t5_rf1", S_RINSE_FILL, 20);
        level_sensor = 300; goto_state("t5_r1", S_RINSE, 10);
        level_sensor = 0;   goto_state("t5_spin", S_SPIN, 20);
        chk("t5_rem4", remaining, 4);
        tick();
        chk("t5_rem3", remaining, 3);
        vibration = 1; tick();
        chk("t5_fault", state_o, S_FAULT);
        chk("t5_code", fault_code, 3);
        chk("t5_f_rem", remaining, 3);
        chk("t5_f_act", {drain_pump, drum_motor, door_lock}, {1'b0, 11'd0, 1'b1});
        resume = 1; tick(); resume = 0;
        chk("t5_res_ign", state_o, S_FAULT);
        vibration = 0; tick();
        chk("t5_no_res", state_o, S_FAULT);
        resume = 1; tick(); resume = 0;
        chk("t5_back", state_o, S_SPIN);
        chk("t5_back_rem", remaining, 3);
        chk("t5_back_code", fault_code, 0);
        dwell(S_SPIN, n);
        chk("t5_spin_tail", n, 4);
        chk("t5_done", state_o, S_DONE);
        tick();
        chk("t5_done_count", done_cnt, 2);

        // Asynchronous reset during HEAT
        level_sensor = 300; temp_sensor = 20;
        start = 1; tick(); start = 0;
        tick();
        chk("t6_heat", state_o, S_HEAT);
        chk("t6_heater", heater, 1);
        #2 reset_n = 0;
        #1;
        chk("t6_async_state", state_o, S_IDLE);
        chk("t6_async_outs", {door_lock, water_valve, heater, drain_pump, busy, done}, 0);
        chk("t6_async_drum", drum_motor, 0);
        tick(); tick();
        reset_n = 1;
        door_closed = 0; start = 1;
        tick(); tick();
        start = 0;
        chk("t6_door_open", state_o, S_IDLE);
        chk("t6_door_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
